// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result bundle for the shift-add multiplier: start/a/b in; busy/done/product out.
// The controller side drives operands with start; the multiplier side returns a registered product.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock; WIDTH cycles (fewer with EARLY_TERM_EN).
// start is ignored while busy; done pulses one cycle alongside the updated product.
module seq_shift_add_multiplier #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_shift_add_multiplier_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] product;
  logic               done;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_sum   = acc + (mplier[0] ? mcand : '0);
`ifdef EARLY_TERM_EN
    // Stop once no set multiplier bits remain above the one consumed this cycle.
    last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif
    case (state)
      IDLE: if (bus.start) state_nxt = CALC;
      CALC: if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // product only ever takes the completed sum, never a partial one.
          if (last_iter) begin
            product <= acc_sum;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = done;
  assign bus.product = product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier at WIDTH=8 with hand-computed products and latencies.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cycles;

  seq_shift_add_multiplier_if #(.WIDTH(W)) bus ();

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done after the accepting edge has already passed.
  task automatic wait_done();
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int exp_lat, input logic [2*W-1:0] exp_p);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done();
    check({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_prod"}, 32'(bus.product), 32'(exp_p));
    tick();
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #3;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_prod", 32'(bus.product), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // 13*11 with per-cycle busy/done tracking
    bus.a = 8'd13;
    bus.b = 8'd11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = 8'd99;
    bus.b = 8'd77;
    for (int i = 1; i < 8; i++) begin
      check("t1_busy_mid", 32'(bus.busy), 32'd1);
      check("t1_done_mid", 32'(bus.done), 32'd0);
      tick();
    end
    check("t1_busy_mid", 32'(bus.busy), 32'd1);
    tick();
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy_end", 32'(bus.busy), 32'd0);
    check("t1_prod", 32'(bus.product), 32'd143);
    tick();
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_prod_hold", 32'(bus.product), 32'd143);

    do_op("max", 8'd255, 8'd255, 8, 16'hFE01);
    do_op("zero_a", 8'd0, 8'd200, 8, 16'd0);

    // start held high: second op accepted on the edge that clears done
    bus.a = 8'd3;
    bus.b = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.a = 8'd7;
    bus.b = 8'd9;
    wait_done();
    check("b2b_lat1", 32'(cycles), 32'd8);
    check("b2b_prod1", 32'(bus.product), 32'd15);
    tick();
    check("b2b_done_clr", 32'(bus.done), 32'd0);
    check("b2b_busy2", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done();
    check("b2b_lat2", 32'(cycles), 32'd8);
    check("b2b_prod2", 32'(bus.product), 32'd63);
    tick();
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // start re-pulsed mid-operation must be ignored
    bus.a = 8'd13;
    bus.b = 8'd11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.a = 8'd1;
    bus.b = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();
    check("ign_lat", 32'(cycles), 32'd4);
    check("ign_prod", 32'(bus.product), 32'd143);
    tick();

    // asynchronous reset mid-calculation (cnt=4)
    bus.a = 8'd13;
    bus.b = 8'd11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_prod", 32'(bus.product), 32'd0);
    tick();
    check("arst_done_held", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("arst_no_pulse", 32'(bus.done), 32'd0);
    do_op("post_rst", 8'd6, 8'd7, 8, 16'd42);

`ifdef EARLY_TERM_EN
    do_op("et_b1", 8'd100, 8'd1, 1, 16'd100);
    do_op("et_b80", 8'd3, 8'h80, 8, 16'h0180);
    do_op("et_b0", 8'd55, 8'd0, 1, 16'd0);
`else
    do_op("fix_b1", 8'd100, 8'd1, 8, 16'd100);
    do_op("fix_b0", 8'd55, 8'd0, 8, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
